// File: rtl/eng_ctrl_sched.sv
// eng_ctrl_sched: sequencing controller for the encode engine pipeline.
// Flushes the engine, strobes the BMU select / AND-mask / global config
// registers, runs the engine under outbuf back-pressure, counts packets in
// and out until the stripe length is reached, drains the pipeline and
// pulses done. A one-cycle ABORT state kills a stripe at any point.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort, num_pkts   host stripe control
//   cfg_valid                host configuration data ready
//   eng_data_used, eng_pl_empty, eng_outbuf_wr_req   engine status
//   outbuf_eng_wr_ack, outbuf_eng_full               outbuf status
//   cntrl_eng_calc_en        engine advance enable (combinational stall)
//   eng_rstn                 engine flush, active low
//   bmu_bm_mux_sel_reg_wr, and_mask_mask_reg_wr, global_reg_wr_en  config strobes
//   busy, done, aborted, overrun                      status
//   pkts_in_cnt, pkts_out_cnt                         packet counters
module eng_ctrl_sched #(
    parameter int unsigned PKT_CNT_W    = 16,
    parameter int unsigned ENG_PL_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PKT_CNT_W-1:0] num_pkts,
    input  logic                 cfg_valid,
    input  logic                 eng_data_used,
    input  logic                 eng_pl_empty,
    input  logic                 eng_outbuf_wr_req,
    input  logic                 outbuf_eng_wr_ack,
    input  logic                 outbuf_eng_full,
    output logic                 cntrl_eng_calc_en,
    output logic                 eng_rstn,
    output logic                 bmu_bm_mux_sel_reg_wr,
    output logic                 and_mask_mask_reg_wr,
    output logic                 global_reg_wr_en,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 overrun,
    output logic [PKT_CNT_W-1:0] pkts_in_cnt,
    output logic [PKT_CNT_W-1:0] pkts_out_cnt
);

    localparam logic [PKT_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PKT_CNT_W-1:0] CNT_ONE = PKT_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_CFG_WAIT,
        S_CFG_WR,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ABORT
    } state_e;

    state_e                 state_q, state_d;
    logic [PKT_CNT_W-1:0]   num_pkts_q, num_pkts_d;
    logic [PKT_CNT_W-1:0]   pkts_in_cnt_q, pkts_in_cnt_d;
    logic [PKT_CNT_W-1:0]   pkts_out_cnt_q, pkts_out_cnt_d;
    logic                   aborted_q, aborted_d;
    logic                   overrun_q, overrun_d;
    logic                   eng_rstn_q, eng_rstn_d;
    logic                   cfg_wr_q, cfg_wr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   start_ok;
    logic                   abort_ok;
    logic                   wr_done;

    // Pipeline depth only shapes the end-of-stripe latency; no logic depends on it.
    logic unused_pl_depth;
    assign unused_pl_depth = (ENG_PL_DEPTH != 0);

    assign start_ok = start && (state_q == S_IDLE);
    // A repeated abort while already in ABORT is absorbed so ABORT stays one cycle.
    assign abort_ok = abort && (state_q != S_IDLE) && (state_q != S_DONE)
                      && (state_q != S_ABORT);
    assign wr_done  = eng_outbuf_wr_req && outbuf_eng_wr_ack;

    // Zero-cycle stall path: the engine stops in the same cycle the outbuf fills.
    assign cntrl_eng_calc_en = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !outbuf_eng_full;

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            num_pkts_q     <= '0;
            pkts_in_cnt_q  <= '0;
            pkts_out_cnt_q <= '0;
            aborted_q      <= 1'b0;
            overrun_q      <= 1'b0;
            eng_rstn_q     <= 1'b1;
            cfg_wr_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_pkts_q     <= num_pkts_d;
            pkts_in_cnt_q  <= pkts_in_cnt_d;
            pkts_out_cnt_q <= pkts_out_cnt_d;
            aborted_q      <= aborted_d;
            overrun_q      <= overrun_d;
            eng_rstn_q     <= eng_rstn_d;
            cfg_wr_q       <= cfg_wr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Next-state, counters, sticky flags and next-cycle output decode.
    always_comb begin
        state_d        = state_q;
        num_pkts_d     = num_pkts_q;
        pkts_in_cnt_d  = pkts_in_cnt_q;
        pkts_out_cnt_d = pkts_out_cnt_q;
        aborted_d      = aborted_q;
        overrun_d      = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_pkts == '0) ? S_DONE : S_FLUSH;
                end
            end
            S_FLUSH:    state_d = S_CFG_WAIT;
            S_CFG_WAIT: begin
                if (cfg_valid) begin
                    state_d = S_CFG_WR;
                end
            end
            S_CFG_WR:   state_d = S_RUN;
            S_RUN: begin
                if (eng_data_used && (pkts_in_cnt_q == (num_pkts_q - CNT_ONE))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((pkts_out_cnt_q == num_pkts_q) && eng_pl_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:     state_d = S_IDLE;
            S_ABORT:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        if (abort_ok) begin
            state_d   = S_ABORT;
            aborted_d = 1'b1;
        end

        // Counters freeze on the abort cycle and saturate at all-ones.
        if (!abort_ok) begin
            if ((state_q == S_RUN) && eng_data_used && (pkts_in_cnt_q != CNT_MAX)) begin
                pkts_in_cnt_d = pkts_in_cnt_q + CNT_ONE;
            end
            if (((state_q == S_RUN) || (state_q == S_DRAIN)) && wr_done
                && (pkts_out_cnt_q != CNT_MAX)) begin
                pkts_out_cnt_d = pkts_out_cnt_q + CNT_ONE;
            end
        end

        // Data consumed after the stripe is complete is flagged, not counted.
        if ((state_q == S_DRAIN) && eng_data_used) begin
            overrun_d = 1'b1;
        end

        if (start_ok) begin
            num_pkts_d     = num_pkts;
            pkts_in_cnt_d  = '0;
            pkts_out_cnt_d = '0;
            aborted_d      = 1'b0;
            overrun_d      = 1'b0;
        end

        eng_rstn_d = !((state_d == S_FLUSH) || (state_d == S_ABORT));
        cfg_wr_d   = (state_d == S_CFG_WR);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    assign eng_rstn              = eng_rstn_q;
    assign bmu_bm_mux_sel_reg_wr = cfg_wr_q;
    assign and_mask_mask_reg_wr  = cfg_wr_q;
    assign global_reg_wr_en      = cfg_wr_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign aborted               = aborted_q;
    assign overrun               = overrun_q;
    assign pkts_in_cnt           = pkts_in_cnt_q;
    assign pkts_out_cnt          = pkts_out_cnt_q;

endmodule
